mux_rr_scheduler: RTL and testbench
===================================

// Module: mux_rr_scheduler
// PURPOSE
//   Round-robin scheduler that shares one N:1 single-bit mux channel between N requesters.
//   Arbitrates req[], holds a grant for a bounded burst, and drives the mux select.
//   Forwards the owner's ch_in bit to ch_out, so it wraps the mux with its sequencing control.
//   Sits between N serial sources and one shared downstream serial sink.
// PARAMETERS
//   N          8               number of requesters / mux inputs (N >= 2, need not be a power of 2)
//   M          $clog2(N)       select width
//   MAX_BURST  16              max consecutive grant cycles per ownership (>= 1)
//   BW         $clog2(MAX_BURST) burst counter width (minimum 1)
// PORTS
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous reset, active-high
//   req      in   N   request per requester, level-sensitive
//   ch_in    in   N   serial data bit per requester
//   grant    out  N   one-hot grant, registered; all-zero when idle
//   select   out  M   registered mux select = index of owner; holds last owner when idle
//   busy     out  1   registered; 1 while a grant is held
//   expire   out  1   registered 1-cycle pulse: grant revoked because MAX_BURST was reached
//   ch_out   out  1   ch_in[select] when busy, else 0 (combinational from ch_in)
// BEHAVIOUR
//   - One clock and synchronous active-high reset, as stated in PORTS.
//   - Reset: state=IDLE, grant=0, select=0, busy=0, expire=0, ptr=0, cnt=0.
//     Reset takes effect at the next edge, including mid-burst.
//   - Internal state: ptr (M bits, highest-priority index), cnt (BW bits).
//   - FSM states are IDLE and GRANT.
//   - IDLE, at an edge with |req:
//     - Winner w = first set req[i] scanning i = ptr, ptr+1, ... N-1, 0, ... ptr-1.
//     - grant<=1<<w, select<=w, busy<=1, cnt<=0, go to GRANT.
//     - Latency is 1 cycle from req being sampled to grant visible.
//   - IDLE, at an edge with req==0: hold all outputs and stay in IDLE.
//   - GRANT, at each edge:
//     - If req[select]==0 or cnt==MAX_BURST-1, release:
//       - grant<=0, busy<=0, ptr<=(select==N-1)?0:select+1, go to IDLE.
//       - expire<=1 only if req[select]==1 (burst limit reached).
//     - Otherwise cnt<=cnt+1 and grant, select, busy hold.
//   - expire is 0 on every edge that does not perform a limit release.
//   - Max ownership is exactly MAX_BURST cycles with grant high.
//   - A requester that drops req keeps grant for the cycle in which req is low; grant falls at the next edge.
//   - Every release is followed by at least 1 idle cycle (grant=0) before any new grant.
//   - ptr wraps modulo N. Indices >= N never appear on select, including for N not a power of 2.
//   - The previous owner re-requesting gets lowest priority. If it is the only requester, it is re-granted after the idle gap.
//   - Requests arriving while in GRANT are ignored until the next IDLE arbitration.
//   - A mid-burst change in other req bits does not preempt the owner.
// TESTING
//   1. Reset, req=0 -> grant=0, select=0, busy=0, expire=0, ch_out=0. Hold for 5 cycles, outputs unchanged.
//   2. Single requester, req=8'h08 held for 40 cycles:
//      - grant=8'h08 for 16 cycles.
//      - expire pulses on the edge that clears grant.
//      - 1 cycle with grant=0, then grant=8'h08 again.
//   3. All requesters, req=8'hFF held:
//      - Grant order is indices 0,1,2,...,7,0.
//      - Each grant lasts 16 cycles, separated by 1 idle cycle, and select matches each grant.
//   4. Early drop, req=8'h24:
//      - Index 2 wins first (ptr=0); drop req[2] after 3 granted cycles.
//      - grant falls next edge, expire=0, ptr=3, then index 5 is granted.
//   5. Data path, owner=6, ch_in[6] toggling each cycle, other ch_in bits=1:
//      - ch_out follows ch_in[6] exactly.
//      - When idle, ch_out=0.
//   6. Reset mid-burst, rst=1 on cycle 5 of grant to index 3:
//      - Next edge gives grant=0, busy=0, select=0.
//      - After rst drops with req=8'hFF, index 0 is granted (ptr reset to 0).

Source files
------------

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of one shared N:1 single-bit mux channel.
// Ports: clk, rst (sync, active-high), req[N], ch_in[N] -> grant[N], select[M], busy, expire, ch_out.
module mux_rr_scheduler #(
  parameter int N         = 8,
  parameter int M         = $clog2(N),
  parameter int MAX_BURST = 16,
  parameter int BW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] ch_in,
  output logic [N-1:0] grant,
  output logic [M-1:0] select,
  output logic         busy,
  output logic         expire,
  output logic         ch_out
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [M-1:0]  LAST    = M'(N - 1);
  localparam logic [BW-1:0] CNT_MAX = BW'(MAX_BURST - 1);

  state_e         state_q, state_d;
  logic [M-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [M-1:0]   sel_q, sel_d;
  logic           busy_q, busy_d;
  logic           exp_q, exp_d;

  logic           found;
  logic [M-1:0]   win;
  logic [M-1:0]   idx;

  // Circular scan starting at ptr; idx wraps explicitly so it
  // never reaches N even when N is not a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    exp_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = N'(1) << win;
          sel_d   = win;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q] || cnt_q == CNT_MAX) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (sel_q == LAST) ? '0 : sel_q + 1'b1;
          // Still requesting at release means the burst limit cut it off.
          exp_d   = req[sel_q];
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      exp_q   <= exp_d;
    end
  end

  assign grant  = grant_q;
  assign select = sel_q;
  assign busy   = busy_q;
  assign expire = exp_q;
  assign ch_out = busy_q & ch_in[sel_q];

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: directed scenarios plus
// random traffic against a behavioural ownership model.
module tb_mux_rr_scheduler;

  localparam int N    = 8;
  localparam int M    = 3;
  localparam int MAXB = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] ch_in;
  logic [N-1:0] grant;
  logic [M-1:0] select;
  logic         busy;
  logic         expire;
  logic         ch_out;

  mux_rr_scheduler #(.N(N), .MAX_BURST(MAXB)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .ch_in  (ch_in),
    .grant  (grant),
    .select (select),
    .busy   (busy),
    .expire (expire),
    .ch_out (ch_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [M-1:0] s;
    logic         b;
    logic         e;
    logic         co;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;
  bit   mon_done = 0;

  // Model: owner index (-1 when idle), cycles owned so far,
  // next priority index, last select and the expire pulse.
  int m_owner = -1;
  int m_held  = 0;
  int m_ptr   = 0;
  int m_sel   = 0;
  bit m_exp   = 0;

  task automatic model_step(input logic r, input logic [N-1:0] q);
    int i;
    m_exp = 0;
    if (r) begin
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (m_owner < 0 && q[i]) begin
          m_owner = i;
          m_sel   = i;
          m_held  = 1;
        end
      end
    end else begin
      if (!q[m_owner] || m_held == MAXB) begin
        m_exp   = q[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic apply(input logic r, input logic [N-1:0] q,
                       input logic [N-1:0] c);
    exp_t e;
    rst   = r;
    req   = q;
    ch_in = c;
    @(posedge clk);
    model_step(r, q);
    e.g  = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.s  = M'(m_sel);
    e.b  = (m_owner >= 0);
    e.e  = m_exp;
    e.co = (m_owner >= 0) ? c[m_sel] : 1'b0;
    sb.push_back(e);
    #3;
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      if (done) break;
      #1;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: no expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        a = '{grant, select, busy, expire, ch_out};
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs @%0t: got g=%h s=%0d b=%b e=%b co=%b want g=%h s=%0d b=%b e=%b co=%b",
                   $time, a.g, a.s, a.b, a.e, a.co, e.g, e.s, e.b, e.e, e.co);
        end
      end
    end
    mon_done = 1;
  end

  initial begin : driver
    logic [N-1:0] c;
    logic [N-1:0] q;
    // Reset then idle hold.
    apply(1'b1, '0, '0);
    repeat (5) apply(1'b0, '0, 8'hA5);
    // Single requester: burst limit, idle gap, re-grant.
    repeat (40) apply(1'b0, 8'h08, 8'hFF);
    // Everyone requests: full rotation and wrap to 0.
    apply(1'b1, '0, '0);
    repeat (9 * (MAXB + 1) + 2) apply(1'b0, 8'hFF, $urandom());
    // Early drop from ptr=0.
    apply(1'b1, '0, '0);
    repeat (4) apply(1'b0, 8'h24, 8'h00);
    repeat (20) apply(1'b0, 8'h20, 8'h20);
    // Data path through owner 6.
    c = 8'hBF;
    repeat (30) begin
      apply(1'b0, 8'h40, c);
      c[6] = ~c[6];
    end
    repeat (3) apply(1'b0, 8'h00, 8'hFF);
    // Reset in the middle of a burst to index 3.
    repeat (6) apply(1'b0, 8'h08, 8'hFF);
    apply(1'b1, 8'hFF, 8'hFF);
    repeat (20) apply(1'b0, 8'hFF, 8'hFF);
    // Random traffic with occasional reset.
    repeat (600) begin
      q = ($urandom_range(0, 3) == 0) ? N'($urandom()) : (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 4) == 0) q = '0;
      apply($urandom_range(0, 79) == 0, q, N'($urandom()));
    end
    done = 1;
  end

  initial begin : finisher
    fork
      wait (mon_done);
      #200000;
    join_any
    if (!mon_done) begin
      n_fail++;
      $display("FAIL timeout: monitor did not complete");
    end
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
